pass_register: RTL
==================

Name: pass_register

Overview:
- Password entry and storage datapath for the combination lock.
- Sits directly beside the lock control FSM, which drives pipo_shift, pipo_load and pipo_reset and consumes pass_check.
- Synchronises the raw 4-bit digit switches and shifts entered digits into an entry register.
- Holds the stored password (loadable at runtime) and produces a registered match flag.

Parameters:
DIGIT_W, 4, width of one entered digit (switch bank width)
DIGITS, 4, number of digits in a password
DEFAULT_PASS, 16'h1234, stored password after reset (width DIGIT_W*DIGITS, first-entered digit in MS nibble)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
digit_in  in  DIGIT_W  raw asynchronous digit switches
pipo_shift  in  1  one-cycle strobe: append current digit to entry
pipo_load  in  1  one-cycle strobe: copy full entry into stored password
pipo_reset  in  1  one-cycle strobe: clear entry
pass_check  out  1  registered: entry full and equal to stored password
entry_count  out  3  number of digits currently in entry (0..DIGITS)
entry_full  out  1  entry_count == DIGITS (combinational from count register)
load_done  out  1  one-cycle pulse, stored password updated

Behaviour:
- Reset (rst_n low at clk edge):
  - Synchroniser flops = 0; entry = 0; entry_count = 0.
  - stored = DEFAULT_PASS; pass_check = 0; load_done = 0.
  - Reset mid-entry or mid-load discards everything; there is no partial-load state.
- Synchroniser: two-flop chain on digit_in gives digit_sync.
  - Latency of 2 clk from a switch change to digit_sync.
  - Only digit_sync is ever sampled.
- Command priority, evaluated per cycle: pipo_reset > pipo_load > pipo_shift. Lower-priority strobes asserted in the same cycle are ignored.
- pipo_reset:
  - entry <= 0; entry_count <= 0.
  - stored unchanged; load_done stays 0.
- pipo_load:
  - If entry_full:
    - stored <= entry; entry <= 0; entry_count <= 0.
    - load_done = 1 for exactly the next cycle.
  - If not full: ignored entirely (stored, entry and count unchanged; no load_done).
- pipo_shift:
  - If entry_count < DIGITS:
    - entry <= {entry[DIGIT_W*(DIGITS-1)-1:0], digit_sync}.
    - entry_count <= entry_count + 1.
  - If full: ignored. No wrap, and entry is not overwritten.
- pass_check:
  - Registered every cycle as entry_full && (entry == stored), based on the pre-edge register values.
  - Valid 1 cycle after the 4th shift.
  - Drops to 0 the cycle after any reset or load that clears entry.
  - After a successful load the cleared entry gives pass_check = 0, even though the new stored value matches the old entry.
- load_done: registered pulse, 1 cycle wide. Back-to-back loads cannot occur, because the entry is empty after a load.
- No internal FSM beyond the count; entry_count saturates at DIGITS.
- entry_count width is fixed at 3 bits for DIGITS <= 7.

Test Plan:
- Reset check: after reset, drive digit_in = 1,2,3,4 with one pipo_shift per digit, each shift >= 3 clk after the digit change. Required: entry_count 1..4, entry_full = 1, pass_check = 1 one cycle after the 4th shift.
- Wrong code: shift 1,2,3,5. Required: pass_check = 0. Then pipo_reset gives entry_count = 0 next cycle, entry_full = 0, pass_check = 0.
- Overflow: shift 1,2,3,4 then shift 9. Required: entry_count stays 4, pass_check stays 1 (fifth shift ignored).
- Runtime change:
  - Shift 9,8,7,6 then pipo_load. Required: load_done = 1 for one cycle, entry_count = 0, pass_check = 0.
  - Then shift 9,8,7,6. Required: pass_check = 1.
  - Then reset + shift 9,8,7,6. Required: pass_check = 0, because stored returns to 16'h1234.
- Partial load and priority:
  - pipo_load with entry_count = 2. Required: no load_done, count stays 2.
  - Full entry, assert pipo_reset and pipo_load in the same cycle. Required: entry cleared, stored unchanged, no load_done.
- Synchroniser and reset mid-entry:
  - Change digit_in and pulse pipo_shift 1 clk later. Required: the old digit_sync value is captured.
  - Assert rst_n = 0 after two shifts. Required: entry_count = 0 and pass_check = 0 at the next edge.

Source files
------------

// File: rtl/pass_register.sv
// pass_register
// Password entry and storage datapath for the combination lock.
// A two-flop synchroniser cleans the raw digit switches. Each pipo_shift
// strobe appends the synchronised digit to the entry register, up to DIGITS
// digits. pipo_load copies a full entry into the stored password, and
// pipo_reset clears the entry. pass_check reports a full entry that matches
// the stored password.
//
// Strobe semantics: pipo_shift, pipo_load and pipo_reset are single-cycle
// command strobes with no back-pressure. Each one is acted on at the rising
// edge where it is high. If several are high at the same edge, only the
// highest-priority one acts: pipo_reset > pipo_load > pipo_shift.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   digit_in     raw asynchronous digit switches (DIGIT_W bits)
//   pipo_shift   strobe: append digit_sync to the entry
//   pipo_load    strobe: copy a full entry into the stored password
//   pipo_reset   strobe: clear the entry
//   pass_check   registered: entry full and equal to the stored password
//   entry_count  number of digits currently in the entry (0..DIGITS)
//   entry_full   entry_count == DIGITS
//   load_done    one-cycle pulse after the stored password is updated
module pass_register #(
  parameter int DIGIT_W = 4,
  parameter int DIGITS = 4,
  parameter logic [DIGIT_W*DIGITS-1:0] DEFAULT_PASS = 16'h1234
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               pipo_shift,
  input  logic               pipo_load,
  input  logic               pipo_reset,
  output logic               pass_check,
  output logic [2:0]         entry_count,
  output logic               entry_full,
  output logic               load_done
);

  localparam int ENTRY_W = DIGIT_W * DIGITS;
  localparam logic [2:0] FULL_COUNT = 3'(DIGITS);

  logic [DIGIT_W-1:0] digit_meta;
  logic [DIGIT_W-1:0] digit_sync;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] stored;
  logic [ENTRY_W-1:0] entry_shifted;

  assign entry_full = (entry_count == FULL_COUNT);

  // The oldest digit moves towards the MS end, so the first-entered digit
  // ends up in the MS nibble once the entry is full.
  assign entry_shifted = (entry << DIGIT_W) | ENTRY_W'(digit_sync);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_meta  <= '0;
      digit_sync  <= '0;
      entry       <= '0;
      entry_count <= '0;
      stored      <= DEFAULT_PASS;
      pass_check  <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      digit_meta <= digit_in;
      digit_sync <= digit_meta;
      load_done  <= 1'b0;
      // Uses pre-edge entry/stored, so a clearing command shows up as a
      // drop of pass_check one cycle later.
      pass_check <= entry_full && (entry == stored);

      if (pipo_reset) begin
        entry       <= '0;
        entry_count <= '0;
      end else if (pipo_load) begin
        // A partial entry is never loaded; the strobe is then a no-op.
        if (entry_full) begin
          stored      <= entry;
          entry       <= '0;
          entry_count <= '0;
          load_done   <= 1'b1;
        end
      end else if (pipo_shift && !entry_full) begin
        entry       <= entry_shifted;
        entry_count <= entry_count + 3'd1;
      end
    end
  end

endmodule
